// File: rtl/positron_layer_serializer_pkg.sv
// positron_layer_serializer_pkg: shared types and helpers for the positron layer serializer.
package positron_layer_serializer_pkg;

    typedef enum logic {SER_COLLECT, SER_SEND} serializer_state_t;

    // Ceiling log2 with a floor of 1 so single-entry indices stay one bit wide.
    function automatic int log2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/positron_layer_serializer.sv
// positron_layer_serializer: gathers one eow-tagged result per upstream lane, then
// replays them as a single sow/eow framed window, lane k as word k.
module positron_layer_serializer
    import positron_layer_serializer_pkg::*;
#(
    parameter int POSIT_WIDTH = 4,
    parameter int NB_POSITRON = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NB_POSITRON-1:0]             rts_i,
    input  logic [NB_POSITRON-1:0]             eow_i,
    input  logic [NB_POSITRON*POSIT_WIDTH-1:0] posit_i,
    output logic [NB_POSITRON-1:0]             rtr_o,
    input  logic                               rtr_i,
    output logic                               rts_o,
    output logic                               sow_o,
    output logic                               eow_o,
    output logic [POSIT_WIDTH-1:0]             posit_o
);

    localparam int IW = log2(NB_POSITRON);
    localparam logic [IW-1:0] LAST = IW'(NB_POSITRON - 1);

    serializer_state_t                            state_q, state_d;
    logic [NB_POSITRON-1:0]                       captured_q, captured_d;
    logic [IW-1:0]                                idx_q, idx_d;
    logic [NB_POSITRON-1:0][POSIT_WIDTH-1:0]      buffer_q, buffer_d;

    always_comb begin
        state_d    = state_q;
        captured_d = captured_q;
        idx_d      = idx_q;
        buffer_d   = buffer_q;
        rtr_o      = '0;
        rts_o      = 1'b0;
        sow_o      = 1'b0;
        eow_o      = 1'b0;
        posit_o    = '0;
        if (state_q == SER_COLLECT) begin
            rtr_o = ~captured_q;
            // Words without eow are intermediate results: accepted but dropped.
            for (int k = 0; k < NB_POSITRON; k++)
                if (rts_i[k] && !captured_q[k] && eow_i[k]) begin
                    buffer_d[k]   = posit_i[k*POSIT_WIDTH +: POSIT_WIDTH];
                    captured_d[k] = 1'b1;
                end
            if (&captured_d) begin
                state_d = SER_SEND;
                idx_d   = '0;
            end
        end else begin
            rts_o   = 1'b1;
            posit_o = buffer_q[idx_q];
            sow_o   = (idx_q == '0);
            eow_o   = (idx_q == LAST);
            if (rtr_i) begin
                if (idx_q == LAST) begin
                    captured_d = '0;
                    idx_d      = '0;
                    state_d    = SER_COLLECT;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SER_COLLECT;
            captured_q <= '0;
            idx_q      <= '0;
            buffer_q   <= '0;
        end else begin
            state_q    <= state_d;
            captured_q <= captured_d;
            idx_q      <= idx_d;
            buffer_q   <= buffer_d;
        end
    end

endmodule
